// File: rtl/subleq_pc_mt_pkg.sv
// Shared constants for the multithreaded SUBLEQ program-counter unit and
// its round-robin helper.
package subleq_pc_mt_pkg;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_THREADS = 4;
    localparam int DEFAULT_STEP    = 1;

    // Slot reached by moving `off` positions forward from `idx` in a ring of `n` slots.
    function automatic int wrap_idx(input int idx, input int off, input int n);
        return (idx + off) % n;
    endfunction

endpackage

// File: rtl/subleq_rr_next.sv
// Combinational circular search: first set bit of run_i strictly after
// cur_i, wrapping around; offset THREADS lands back on cur_i itself, so a
// lone running current thread is re-selected.
module subleq_rr_next
    import subleq_pc_mt_pkg::*;
#(
    parameter int  THREADS = DEFAULT_THREADS,
    localparam int TW      = $clog2(THREADS)
) (
    input  logic [THREADS-1:0] run_i,
    input  logic [TW-1:0]      cur_i,
    output logic [TW-1:0]      next_o,
    output logic               any_o
);

    logic          found;
    logic [TW-1:0] idx;

    // Scan forward from cur_i+1 and latch the first running slot found.
    always_comb begin
        next_o = cur_i;
        found  = 1'b0;
        idx    = cur_i;
        for (int k = 1; k <= THREADS; k++) begin
            idx = TW'(wrap_idx(int'(cur_i), k, THREADS));
            if (!found && run_i[idx]) begin
                found  = 1'b1;
                next_o = idx;
            end
        end
    end

    assign any_o = |run_i;

endmodule

// File: rtl/subleq_pc_mt.sv
// Multithreaded program counter: THREADS independent PCs, one committed
// update per enabled cycle, round-robin rotation over running threads.
// Every output decodes from registers only.
module subleq_pc_mt
    import subleq_pc_mt_pkg::*;
#(
    parameter int  WIDTH        = DEFAULT_WIDTH,
    parameter int  THREADS      = DEFAULT_THREADS,
    parameter int  STEP         = DEFAULT_STEP,
    parameter int  HALT_ON_SELF = 1,
    localparam int TW           = $clog2(THREADS)
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               en,
    input  logic               branch,
    input  logic               inc,
    input  logic               halt,
    input  logic [WIDTH-1:0]   addr,
    input  logic               start_valid,
    input  logic [TW-1:0]      start_tid,
    input  logic [WIDTH-1:0]   start_addr,
    output logic [WIDTH-1:0]   pc_out,
    output logic [TW-1:0]      tid_out,
    output logic               valid_out,
    output logic [THREADS-1:0] halted,
    output logic               all_halted
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0]   pc_q [THREADS];
    logic [WIDTH-1:0]   pc_d [THREADS];
    logic [THREADS-1:0] run_q, run_d;
    logic [TW-1:0]      cur_q, cur_d;

    logic [WIDTH-1:0]   cur_pc;
    logic               commit;
    logic               self_branch;
    logic               launch_ok;
    logic [TW-1:0]      rr_next;
    logic               rr_any;

    assign cur_pc      = pc_q[cur_q];
    // A dead current slot cannot commit, which also makes the control inputs
    // irrelevant whenever valid_out is low.
    assign commit      = en && run_q[cur_q];
    assign self_branch = (HALT_ON_SELF != 0) && branch && (addr == cur_pc);
    assign launch_ok   = start_valid && (int'(start_tid) < THREADS);

    // Per-thread PC/run update; the launch is applied last so it overrides
    // a same-cycle commit on the same thread.
    always_comb begin
        pc_d  = pc_q;
        run_d = run_q;
        if (commit) begin
            if (branch) begin
                pc_d[cur_q] = addr;
            end else if (inc) begin
                pc_d[cur_q] = cur_pc + STEP_W;
            end
            if (halt || self_branch) begin
                run_d[cur_q] = 1'b0;
            end
        end
        if (launch_ok) begin
            pc_d[start_tid]  = start_addr;
            run_d[start_tid] = 1'b1;
        end
    end

    subleq_rr_next #(
        .THREADS (THREADS)
    ) u_rr_next (
        .run_i  (run_d),
        .cur_i  (cur_q),
        .next_o (rr_next),
        .any_o  (rr_any)
    );

    // Rotate after a commit, or skip off a dead slot; a stalled live thread keeps its slot.
    always_comb begin
        cur_d = cur_q;
        if ((commit || !run_q[cur_q]) && rr_any) begin
            cur_d = rr_next;
        end
    end

    // State registers with synchronous reset: only thread 0 runs from PC 0.
    always_ff @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < THREADS; i++) begin
                pc_q[i] <= '0;
            end
            run_q <= THREADS'(1);
            cur_q <= '0;
        end else begin
            pc_q  <= pc_d;
            run_q <= run_d;
            cur_q <= cur_d;
        end
    end

    assign pc_out     = cur_pc;
    assign tid_out    = cur_q;
    assign valid_out  = run_q[cur_q];
    assign halted     = ~run_q;
    assign all_halted = &halted;

endmodule
